// File: rtl/prog1_pkg.sv
// ============================================================================
// Module      : prog1_pkg
// Description : Shared types, default parameters and the SECDED encode
//               function for the program-1 Hamming encoder engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog1_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int DEF_NUM_MSG   = 15;
    localparam int DEF_IN_BASE   = 0;
    localparam int DEF_OUT_BASE  = 30;
    localparam int DEF_MEM_DEPTH = 256;

    // cw = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage : prog1_pkg

`default_nettype wire

// File: rtl/dat_mem.sv
// ============================================================================
// Module      : dat_mem
// Description : Byte-wide data memory, combinational read / synchronous write.
//               Contents are deliberately not touched by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dat_mem #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                         Clk,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [7:0]                   data_in,
    output logic [7:0]                   data_out
);

    logic [7:0] memory [MEM_DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            memory[addr] <= data_in;
        end
    end

    assign data_out = memory[addr];

endmodule : dat_mem

`default_nettype wire

// File: rtl/top_level.sv
// ============================================================================
// Module      : top_level
// Description : Hamming SECDED encoder engine: reads NUM_MSG 11-bit messages
//               from dat_mem, writes 16-bit codewords back, raises Done.
//               Optional macro CYCLE_COUNT_EN adds the Cycles run counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_level
    import prog1_pkg::*;
#(
    parameter int NUM_MSG   = DEF_NUM_MSG,
    parameter int IN_BASE   = DEF_IN_BASE,
    parameter int OUT_BASE  = DEF_OUT_BASE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
`ifdef CYCLE_COUNT_EN
    output logic [15:0] Cycles,
`endif
    output logic        Done
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);
    localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      lo_q, lo_d;
    logic [2:0]      hi_q, hi_d;
    logic            done_q, done_d;

    logic            mem_wr_en;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic [AW-1:0]   msg_off;
    logic [15:0]     cw;
    logic            start_acc;
    logic            unused_hi_bits;

    // Address offset wraps naturally at the memory address width.
    assign msg_off        = AW'({idx_q, 1'b0});
    assign cw             = hamming_encode({hi_q, lo_q});
    assign start_acc      = Start && ((state_q == IDLE) || (state_q == FIN));
    assign unused_hi_bits = ^mem_rdata[7:3];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        done_d    = done_q;
        mem_wr_en = 1'b0;
        mem_addr  = IN_BASE_A + msg_off;
        mem_wdata = cw[7:0];
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RD_LO: begin
                mem_addr = IN_BASE_A + msg_off;
                lo_d     = mem_rdata;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = IN_BASE_A + msg_off + AW'(1);
                hi_d     = mem_rdata[2:0];
                state_d  = WR_LO;
            end
            WR_LO: begin
                mem_addr  = OUT_BASE_A + msg_off;
                mem_wr_en = 1'b1;
                mem_wdata = cw[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_addr  = OUT_BASE_A + msg_off + AW'(1);
                mem_wr_en = 1'b1;
                mem_wdata = cw[15:8];
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            FIN: begin
                // Done registers one cycle after entering FIN; Start restarts.
                if (Start) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    assign Done = done_q;

`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_acc) begin
            cyc_d = '0;
        end else if ((state_q != IDLE) && !done_q && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign Cycles = cyc_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    dat_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) dm1 (
        .Clk      (Clk),
        .wr_en    (mem_wr_en),
        .addr     (mem_addr),
        .data_in  (mem_wdata),
        .data_out (mem_rdata)
    );

endmodule : top_level

`default_nettype wire

// File: tb/tb_top_level.sv
// ============================================================================
// Module      : tb_top_level
// Description : Self-checking bench for the Hamming encoder engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_level;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 30;
    localparam int LATENCY  = 4 * NUM_MSG + 1;

    logic clk;
    logic rst_n;
    logic start;
    logic done;
`ifdef CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [10:0] msgs   [NUM_MSG];
    logic [7:0]  in_img [2*NUM_MSG];

    top_level dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Start  (start),
`ifdef CYCLE_COUNT_EN
        .Cycles (cycles),
`endif
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: classic Hamming positions (parity at powers of two),
    // overall parity at bit 0.
    function automatic logic [15:0] ref_cw(input logic [10:0] d);
        logic [15:0] c;
        int dpos [11];
        logic par;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        c = '0;
        for (int k = 0; k < 11; k++) c[dpos[k]] = d[k];
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int j = 1; j < 16; j++) if ((j & p) != 0) par = par ^ c[j];
            c[p] = par;
        end
        par = 1'b0;
        for (int j = 1; j < 16; j++) par = par ^ c[j];
        c[0] = par;
        return c;
    endfunction

    function automatic logic [15:0] mem_cw(input int i);
        return {dut.dm1.memory[OUT_BASE + 2*i + 1], dut.dm1.memory[OUT_BASE + 2*i]};
    endfunction

    task automatic preload();
        @(negedge clk);
        for (int i = 0; i < NUM_MSG; i++) begin
            in_img[2*i]     = msgs[i][7:0];
            in_img[2*i + 1] = {5'($urandom), msgs[i][10:8]};
            dut.dm1.memory[IN_BASE + 2*i]      = in_img[2*i];
            dut.dm1.memory[IN_BASE + 2*i + 1]  = in_img[2*i + 1];
            dut.dm1.memory[OUT_BASE + 2*i]     = 8'hA5;
            dut.dm1.memory[OUT_BASE + 2*i + 1] = 8'hA5;
        end
    endtask

    task automatic randomize_msgs();
        for (int i = 0; i < NUM_MSG; i++) msgs[i] = 11'($urandom);
    endtask

    // Start pulse, then count clocks until Done; lat=-1 on timeout.
    task automatic do_run(input int busy_a, input int busy_b,
                          output int lat, output logic done_after);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_after = done;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == busy_a) || (lat == busy_b);
            if (done) break;
        end
        start = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done actual=%b required=0", done);
        end
`ifdef CYCLE_COUNT_EN
        checks++;
        if (cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_cycles actual=%0d required=0", cycles);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle_done actual=%b required=0", done);
        end
    endtask

    task automatic test_directed();
        int lat;
        logic da;
        logic [15:0] exp_c [3];
        randomize_msgs();
        msgs[0] = 11'h000;
        msgs[1] = 11'h7FF;
        msgs[2] = 11'h001;
        exp_c = '{16'h0000, 16'hFFFF, 16'h000F};
        preload();
        do_run(0, 0, lat, da);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL directed_latency actual=%0d required=%0d", lat, LATENCY);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_cw(i) !== exp_c[i]) begin
                errors++;
                $display("FAIL directed_cw%0d actual=%h required=%h", i, mem_cw(i), exp_c[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic da;
        for (int r = 0; r < 3; r++) begin
            randomize_msgs();
            preload();
            do_run(0, 0, lat, da);
            checks++;
            if (lat !== LATENCY) begin
                errors++;
                $display("FAIL random_latency run=%0d actual=%0d required=%0d", r, lat, LATENCY);
            end
`ifdef CYCLE_COUNT_EN
            checks++;
            if (cycles !== 16'(LATENCY)) begin
                errors++;
                $display("FAIL random_cycles actual=%0d required=%0d", cycles, LATENCY);
            end
`endif
            for (int i = 0; i < NUM_MSG; i++) begin
                checks++;
                if (mem_cw(i) !== ref_cw(msgs[i])) begin
                    errors++;
                    $display("FAIL random_cw run=%0d msg=%0d actual=%h required=%h",
                             r, i, mem_cw(i), ref_cw(msgs[i]));
                end
            end
            for (int a = 0; a < 2*NUM_MSG; a++) begin
                checks++;
                if (dut.dm1.memory[IN_BASE + a] !== in_img[a]) begin
                    errors++;
                    $display("FAIL input_kept addr=%0d actual=%h required=%h",
                             a, dut.dm1.memory[IN_BASE + a], in_img[a]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic da;
        randomize_msgs();
        preload();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_done actual=%b required=0", done);
        end
        // Messages 0..4 completed before the reset; later slots untouched.
        for (int i = 0; i < NUM_MSG; i++) begin
            logic [15:0] want;
            want = (i < 5) ? ref_cw(msgs[i]) : 16'hA5A5;
            checks++;
            if (mem_cw(i) !== want) begin
                errors++;
                $display("FAIL midrun_partial msg=%0d actual=%h required=%h", i, mem_cw(i), want);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ((done !== 1'b0) || (mem_cw(5) !== 16'hA5A5)) begin
            errors++;
            $display("FAIL midrun_idle done=%b cw5=%h required done=0 cw5=a5a5", done, mem_cw(5));
        end
        do_run(0, 0, lat, da);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL rerun_latency actual=%0d required=%0d", lat, LATENCY);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            checks++;
            if (mem_cw(i) !== ref_cw(msgs[i])) begin
                errors++;
                $display("FAIL rerun_cw msg=%0d actual=%h required=%h", i, mem_cw(i), ref_cw(msgs[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic da;
        randomize_msgs();
        preload();
        do_run(10, 30, lat, da);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL busy_start_latency actual=%0d required=%0d", lat, LATENCY);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            checks++;
            if (mem_cw(i) !== ref_cw(msgs[i])) begin
                errors++;
                $display("FAIL busy_cw msg=%0d actual=%h required=%h", i, mem_cw(i), ref_cw(msgs[i]));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_held actual=%b required=1", done);
        end
        randomize_msgs();
        preload();
        do_run(0, 0, lat, da);
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL done_drop actual=%b required=0", da);
        end
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL repeat_latency actual=%0d required=%0d", lat, LATENCY);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            checks++;
            if (mem_cw(i) !== ref_cw(msgs[i])) begin
                errors++;
                $display("FAIL repeat_cw msg=%0d actual=%h required=%h", i, mem_cw(i), ref_cw(msgs[i]));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_top_level

`default_nettype wire
